reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the CPU datapath, the next generation of the single-write, dual-read register file. It provides NUM_WR write ports with byte enables, NUM_RD read ports with optional same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard that the decode stage uses for RAW hazard detection. The entire array and scoreboard clear asynchronously on reset.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads see stored contents only
- ZERO_REG, 1, 1 = address 0 reads as 0, is never written and is never busy
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  NUM_WR  per-port write enable
- wa  in  NUM_WR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- wd  in  NUM_WR*DATA_W  write data, packed the same way
- wbe  in  NUM_WR*DATA_W/8  byte enables; a byte is written only if we[i] and wbe bit set
- ra  in  NUM_RD*ADDR_W  read addresses, packed
- rd  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  busy bit of each ra, combinational
- bs_en  in  1  scoreboard set strobe (instruction issued with a destination)
- bs_addr  in  ADDR_W  destination to mark busy

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a 2**ADDR_W busy vector.
- Write: on each rising edge, for each port i with we[i]=1, every byte b with wbe[i][b]=1 of reg[wa[i]] takes wd[i] byte b. Unenabled bytes are preserved.
- Write conflict: if two ports write the same address in one cycle, the higher-index port wins on each byte that both enable. Bytes enabled by only one port take that port's data.
- ZERO_REG=1: writes to address 0 are discarded, rd for ra=0 is 0, and busy[0] is held at 0.
- Read, BYPASS=0: rd[j] = reg[ra[j]].
- Read, BYPASS=1: rd[j] = reg[ra[j]] with each byte replaced by the winning write-port byte for any port i where we[i], wa[i]=ra[j] and the byte is enabled. The merge uses the same priority as the write.
- ZERO_REG overrides bypass.
- Scoreboard:
  - On an edge, busy[bs_addr] is set if bs_en=1.
  - busy[wa[i]] is cleared if we[i]=1, regardless of wbe.
  - If a set and a clear hit the same address in the same cycle, the set wins (a new producer has issued).
  - rd_busy[j] = busy[ra[j]]. When BYPASS=1 it is also forced to 0 for an address being written this cycle.
- Reset (rst_n=0):
  - All registers and busy bits go to 0 immediately.
  - All writes and scoreboard sets are ignored while reset is asserted.
  - Bypass is suppressed, so rd = 0 and rd_busy = 0 for every port during reset.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible through the stored path from N onward, and through bypass during cycle N-1 when BYPASS=1.
- Read latency: 0 cycles (combinational from ra, array, and, when BYPASS=1, we/wa/wd/wbe).
- Scoreboard latency: 1 cycle. A bit set at edge N shows on rd_busy after edge N.
- Reset:
  - Assertion takes effect without a clock edge.
  - Deassertion is expected to be synchronised externally.
  - The first edge with rst_n=1 performs normal writes.
- Reset mid-write: a write whose edge coincides with rst_n=0 is lost and the register stays 0.
- No combinational path from rd to any input. rd_busy depends only on ra, busy and, when BYPASS=1, we/wa.

## Test plan
- Reset then read: rst_n=0 with the array previously loaded; ra={3,7} -> rd={0,0} and rd_busy=0 before any clock edge.
- Byte write: we0=1, wa0=5, wd0=0xAABBCCDD, wbe0=0b0101 over reg5=0x11223344 -> reg5=0x11BB33DD. With BYPASS=1 and ra=5 in the same cycle, rd=0x11BB33DD before the edge.
- Dual-port conflict: both ports write address 9; port0 wd=0x11111111 wbe=1111, port1 wd=0x22222222 wbe=0011 -> reg9=0x11112222.
- Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF, bs_en=1, bs_addr=0 -> rd for ra=0 is 0 and rd_busy=0, both in that cycle and after.
- Scoreboard:
  - bs_en=1, bs_addr=4 -> rd_busy for ra=4 is 1 after the edge.
  - Later, we0=1, wa0=4 -> rd_busy is 0 in that cycle (BYPASS=1) and 0 after the edge.
  - Simultaneous set and clear on address 4 -> busy stays 1.
- BYPASS=0 build: write reg2=0x5 while ra=2 -> rd shows the old value during the cycle and 0x5 after the edge.

Source files
------------

// File: rtl/reg_file_mp.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reg_file_mp: multi-port register file with byte enables, same-cycle     |
// | write-to-read bypass, hardwired zero register and busy scoreboard.      |
// | Revision: 1.0                                                           |
// +---------------------------------------------------------------------------+
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   wa,
  input  logic [NUM_WR*DATA_W-1:0]   wd,
  input  logic [NUM_WR*DATA_W/8-1:0] wbe,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       bs_en,
  input  logic [ADDR_W-1:0]          bs_addr
);

  localparam int c_DEPTH = 2**ADDR_W;
  localparam int c_NB    = DATA_W/8;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;

  // Ports are applied in ascending order so the higher index wins per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && !(ZERO_REG && (wa[i*ADDR_W +: ADDR_W] == '0))) begin
          for (int b = 0; b < c_NB; b++) begin
            if (wbe[i*c_NB + b]) begin
              r_mem[wa[i*ADDR_W +: ADDR_W]][b*8 +: 8] <= wd[i*DATA_W + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Set is assigned after the clears so a newly issued producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i]) begin
          r_busy[wa[i*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (bs_en) begin
        r_busy[bs_addr] <= 1'b1;
      end
      if (ZERO_REG) begin
        r_busy[0] <= 1'b0;
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_data;
    logic              w_hit;

    assign w_ra = ra[j*ADDR_W +: ADDR_W];

    always_comb begin
      w_hit = 1'b0;
      if (BYPASS) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && (wa[i*ADDR_W +: ADDR_W] == w_ra)) begin
            w_hit = 1'b1;
          end
        end
      end
    end

    always_comb begin
      w_data = r_mem[w_ra];
      if (BYPASS) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && (wa[i*ADDR_W +: ADDR_W] == w_ra)) begin
            for (int b = 0; b < c_NB; b++) begin
              if (wbe[i*c_NB + b]) begin
                w_data[b*8 +: 8] = wd[i*DATA_W + b*8 +: 8];
              end
            end
          end
        end
      end
      // Reset suppresses bypass; the stored array is already clear.
      if (!rst_n || (ZERO_REG && (w_ra == '0))) begin
        w_data = '0;
      end
    end

    assign rd[j*DATA_W +: DATA_W] = w_data;
    assign rd_busy[j]             = r_busy[w_ra] & ~w_hit;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_reg_file_mp: scoreboard testbench for reg_file_mp (bypass and         |
// | non-bypass builds driven in parallel).                                   |
// | Revision: 1.0                                                           |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic [NW*4-1:0]   wbe;
  logic [NR*AW-1:0]  ra;
  logic              bs_en;
  logic [AW-1:0]     bs_addr;
  logic [NR*DW-1:0]  rd, rd_nb;
  logic [NR-1:0]     rd_busy, rd_busy_nb;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra(ra), .rd(rd), .rd_busy(rd_busy), .bs_en(bs_en), .bs_addr(bs_addr));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb), .bs_en(bs_en), .bs_addr(bs_addr));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs[$];
  string       nm[$];
  logic [31:0] e;
  logic [31:0] m[32];

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    v = m[a];
    if (byp) begin
      for (int i = 0; i < NW; i++) begin
        if (we[i] && wa[i*AW +: AW] == a) begin
          for (int b = 0; b < 4; b++) begin
            if (wbe[i*4 + b]) v[b*8 +: 8] = wd[i*DW + b*8 +: 8];
          end
        end
      end
    end
    if (a == 5'd0 || !rst_n) v = '0;
    return v;
  endfunction

  task automatic commit_model();
    for (int i = 0; i < NW; i++) begin
      if (we[i] && wa[i*AW +: AW] != 5'd0) begin
        for (int b = 0; b < 4; b++) begin
          if (wbe[i*4 + b]) m[wa[i*AW +: AW]][b*8 +: 8] = wd[i*DW + b*8 +: 8];
        end
      end
    end
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; wbe = '0; bs_en = 1'b0; bs_addr = '0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
    wbe[p*4 +: 4] = be;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic tick();
    if (rst_n) commit_model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_wr(0, 5'd3, 32'hCAFE0003, 4'hF);
    set_wr(1, 5'd7, 32'hBEEF0007, 4'hF);
    bs_en = 1'b1; bs_addr = 5'd3;
    tick(); idle();
    set_rd(0, 5'd3); set_rd(1, 5'd7);
    exp_q.push_back(32'hCAFE0003); exp_q.push_back(32'hBEEF0007);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("preload_rd0");
    obs.push_back(rd[32 +: 32]); nm.push_back("preload_rd1");
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("preload_busy0");
    obs.push_back({31'd0, rd_busy[1]}); nm.push_back("preload_busy1");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    set_wr(0, 5'd3, 32'h12345678, 4'hF);
    rst_n = 1'b0;
    for (int k = 0; k < 32; k++) m[k] = '0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    obs.push_back(rd[0 +: 32]); nm.push_back("rst_rd0");
    obs.push_back(rd[32 +: 32]); nm.push_back("rst_rd1");
    obs.push_back({30'd0, rd_busy}); nm.push_back("rst_busy");
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("rst_nb_rd0");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    obs.push_back(rd[0 +: 32]); nm.push_back("midwrite_lost_rd0");
    obs.push_back({30'd0, rd_busy}); nm.push_back("post_rst_busy");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    set_wr(0, 5'd5, 32'h11223344, 4'hF);
    tick(); idle();
    set_wr(0, 5'd5, 32'hAABBCCDD, 4'b0101);
    set_rd(0, 5'd5);
    exp_q.push_back(32'h11BB33DD); exp_q.push_back(32'h11223344);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("bw_bypass_rd0");
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("bw_nb_rd0");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    tick(); idle();
    exp_q.push_back(32'h11BB33DD); exp_q.push_back(32'h11BB33DD);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("bw_stored_rd0");
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("bw_nb_stored_rd0");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    set_wr(0, 5'd9, 32'h11111111, 4'hF);
    set_wr(1, 5'd9, 32'h22222222, 4'b0011);
    set_rd(0, 5'd5); set_rd(1, 5'd9);
    exp_q.push_back(32'h11112222); exp_q.push_back(32'h11BB33DD);
    @(negedge clk);
    obs.push_back(rd[32 +: 32]); nm.push_back("conf_bypass_rd1");
    obs.push_back(rd[0 +: 32]); nm.push_back("conf_other_rd0");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    tick(); idle();
    set_wr(0, 5'd10, 32'hA0A0A0A0, 4'hF);
    set_wr(1, 5'd11, 32'hB1B1B1B1, 4'b1000);
    exp_q.push_back(32'h11112222);
    @(negedge clk);
    obs.push_back(rd_nb[32 +: 32]); nm.push_back("conf_stored_rd1");
    tick(); idle();
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    exp_q.push_back(32'hA0A0A0A0); exp_q.push_back(32'hB1000000);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("dual_rd0");
    obs.push_back(rd[32 +: 32]); nm.push_back("dual_rd1");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    set_wr(0, 5'd0, 32'hFFFFFFFF, 4'hF);
    bs_en = 1'b1; bs_addr = 5'd0;
    set_rd(0, 5'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("zero_bypass_rd0");
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("zero_busy_same");
    tick(); idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    obs.push_back(rd[0 +: 32]); nm.push_back("zero_after_rd0");
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("zero_after_busy");
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("zero_nb_rd0");
    obs.push_back({31'd0, rd_busy_nb[0]}); nm.push_back("zero_nb_busy");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_scoreboard();
    bs_en = 1'b1; bs_addr = 5'd4;
    set_rd(0, 5'd4); set_rd(1, 5'd6);
    exp_q.push_back(32'd0);
    @(negedge clk);
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("sb_before_edge");
    tick(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    @(negedge clk);
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("sb_set_busy0");
    obs.push_back({31'd0, rd_busy[1]}); nm.push_back("sb_other_busy1");
    obs.push_back({31'd0, rd_busy_nb[0]}); nm.push_back("sb_nb_set_busy0");
    set_wr(0, 5'd4, 32'h0, 4'b0000);
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("sb_clear_bypass");
    obs.push_back({31'd0, rd_busy_nb[0]}); nm.push_back("sb_clear_nb_same");
    tick(); idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("sb_cleared");
    obs.push_back({31'd0, rd_busy_nb[0]}); nm.push_back("sb_nb_cleared");
    @(posedge clk); #1;
    bs_en = 1'b1; bs_addr = 5'd4;
    tick(); idle();
    bs_en = 1'b1; bs_addr = 5'd4;
    set_wr(0, 5'd4, 32'h0, 4'b0000);
    set_wr(1, 5'd4, 32'h0, 4'b0000);
    tick(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    @(negedge clk);
    obs.push_back({31'd0, rd_busy[0]}); nm.push_back("sb_set_wins");
    obs.push_back({31'd0, rd_busy_nb[0]}); nm.push_back("sb_nb_set_wins");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_bypass0();
    set_wr(0, 5'd2, 32'h00000077, 4'hF);
    tick(); idle();
    set_wr(0, 5'd2, 32'h00000005, 4'hF);
    set_rd(0, 5'd2);
    exp_q.push_back(32'h77); exp_q.push_back(32'h5);
    @(negedge clk);
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("nb_old_value");
    obs.push_back(rd[0 +: 32]); nm.push_back("byp_new_value");
    tick(); idle();
    exp_q.push_back(32'h5); exp_q.push_back(32'h5);
    @(negedge clk);
    obs.push_back(rd_nb[0 +: 32]); nm.push_back("nb_after_edge");
    obs.push_back(rd[0 +: 32]); nm.push_back("byp_after_edge");
    for (int k = 0; k < obs.size(); k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs[k] !== e) begin
        n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
      end
    end
    obs.delete(); nm.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 3) != 0)
          set_wr(p, 5'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
      end
      for (int p = 0; p < NR; p++) set_rd(p, 5'($urandom_range(0, 7)));
      for (int p = 0; p < NR; p++) begin
        exp_q.push_back(model_rd(ra[p*AW +: AW], 1'b1));
        exp_q.push_back(model_rd(ra[p*AW +: AW], 1'b0));
      end
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        obs.push_back(rd[p*DW +: DW]); nm.push_back($sformatf("b2b_c%0d_byp_rd%0d", c, p));
        obs.push_back(rd_nb[p*DW +: DW]); nm.push_back($sformatf("b2b_c%0d_nb_rd%0d", c, p));
      end
      for (int k = 0; k < obs.size(); k++) begin
        e = exp_q.pop_front(); n_checks++;
        if (obs[k] !== e) begin
          n_errors++; $display("FAIL %s: got %h expected %h", nm[k], obs[k], e);
        end
      end
      obs.delete(); nm.delete();
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ra = '0;
    idle();
    for (int k = 0; k < 32; k++) m[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_byte_write();
    test_conflict();
    test_zero();
    test_scoreboard();
    test_bypass0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
